regfile_bank: RTL and testbench

Parametrised register bank that replaces per-block generated register files. It holds NUM_REGS registers of DATA_WIDTH bits on the simple reg_en/reg_we bus. Each register has its own access mode: read/write, read-only hardware input, write-1-to-clear sticky status, or self-clearing write-1 trigger. It sits between the bus decoder and peripheral logic such as GPIO configuration, status and command registers.

---
 rtl/regfile_bank.sv | 131 +++++++++++++
 tb/tb_regfile_bank.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bank.sv
// Parametrised register bank on the reg_en/reg_we bus. Each slot is RW, RO (hardware input),
// W1C sticky status with rising-edge set, or TRIG (self-clearing write-1 pulse).
module regfile_bank #(
  parameter int unsigned                         NUM_REGS   = 4,
  parameter int unsigned                         DATA_WIDTH = 32,
  parameter int unsigned                         ADDR_WIDTH = 6,
  parameter logic [2*NUM_REGS-1:0]               REG_MODE   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]      RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           reg_en,
  input  logic                           reg_we,
  input  logic [ADDR_WIDTH-1:0]          reg_addr,
  input  logic [DATA_WIDTH-1:0]          reg_wdata,
  output logic [DATA_WIDTH-1:0]          reg_rdata,
  output logic                           reg_rvalid,
  output logic                           reg_err,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS*DATA_WIDTH-1:0] trig_out,
  output logic                           irq
);

  typedef enum logic [1:0] {
    ModeRw   = 2'd0,
    ModeRo   = 2'd1,
    ModeW1c  = 2'd2,
    ModeTrig = 2'd3
  } mode_e;

  localparam logic [ADDR_WIDTH:0] NumRegsExt = (ADDR_WIDTH + 1)'(NUM_REGS);

  function automatic mode_e mode_of(int i);
    return mode_e'(REG_MODE[2*i +: 2]);
  endfunction

  // RO and TRIG slots hold no state, so they reset (and stay) at zero.
  function automatic logic [DATA_WIDTH-1:0] reset_of(int i);
    if (mode_of(i) == ModeRw || mode_of(i) == ModeW1c) begin
      return RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
    end
    return '0;
  endfunction

  logic [DATA_WIDTH-1:0]          regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]          regs_d [NUM_REGS];
  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in_q;
  logic [NUM_REGS*DATA_WIDTH-1:0] trig_q, trig_d;
  logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
  logic                           rvalid_q, err_q, irq_q, irq_d;
  logic [NUM_REGS-1:0]            wr_sel, rd_sel;
  logic                           in_range, rd_req;

  assign in_range = {1'b0, reg_addr} < NumRegsExt;
  assign rd_req   = reg_en & ~reg_we;

  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_en && in_range && reg_addr == ADDR_WIDTH'(i)) begin
        if (reg_we) wr_sel[i] = 1'b1;
        else        rd_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    trig_d  = '0;
    irq_d   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      unique case (mode_of(i))
        ModeRw: begin
          if (wr_sel[i]) regs_d[i] = reg_wdata;
          if (rd_sel[i]) rdata_d = regs_q[i];
        end
        ModeRo: begin
          regs_d[i] = '0;
          if (rd_sel[i]) rdata_d = hw_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
        ModeW1c: begin
          // Set is OR-ed in after the clear so a coincident hardware edge wins.
          regs_d[i] = (regs_q[i] & ~(wr_sel[i] ? reg_wdata : '0))
                    | (hw_in[i*DATA_WIDTH +: DATA_WIDTH] & ~hw_in_q[i*DATA_WIDTH +: DATA_WIDTH]);
          irq_d = irq_d | (|regs_q[i]);
          if (rd_sel[i]) rdata_d = regs_q[i];
        end
        ModeTrig: begin
          regs_d[i] = '0;
          if (wr_sel[i]) trig_d[i*DATA_WIDTH +: DATA_WIDTH] = reg_wdata;
        end
        default: regs_d[i] = regs_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reset_of(i);
      hw_in_q  <= '0;
      trig_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      hw_in_q  <= hw_in;
      trig_q   <= trig_d;
      if (rd_req) rdata_q <= rdata_d;
      rvalid_q <= rd_req;
      err_q    <= reg_en & ~in_range;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign trig_out   = trig_q;
  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign reg_err    = err_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: read expectations queued at issue, compared on rvalid.
module tb_regfile_bank;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 6;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              reg_en = 1'b0;
  logic              reg_we = 1'b0;
  logic [AW-1:0]     reg_addr = '0;
  logic [DW-1:0]     reg_wdata = '0;
  logic [DW-1:0]     reg_rdata;
  logic              reg_rvalid;
  logic              reg_err;
  logic [NR*DW-1:0]  hw_in = '0;
  logic [NR*DW-1:0]  reg_q;
  logic [NR*DW-1:0]  trig_out;
  logic              irq;

  int checks = 0;
  int passes = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  regfile_bank #(
    .NUM_REGS  (NR),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .REG_MODE  (8'hE4),
    .RESET_VAL ({32'h0, 32'h0, 32'h0, 32'h0000_00A5})
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .reg_en    (reg_en),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_rvalid(reg_rvalid),
    .reg_err   (reg_err),
    .hw_in     (hw_in),
    .reg_q     (reg_q),
    .trig_out  (trig_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Scoreboard: every rvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (reset_n && reg_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_rvalid: got rdata %h with no read outstanding", reg_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (reg_rdata !== mon_exp)
          $display("FAIL read_data: got %h expected %h", reg_rdata, mon_exp);
        else passes++;
      end
    end
  end

  function automatic logic [DW-1:0] slot(input logic [NR*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    @(negedge clk);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = a;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    reg_en = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      reg_en = 1'b0; reg_we = 1'b0;
    end
  endtask

  task automatic test_reset;
    hw_in[32 +: 32] = 32'h1234_5678;
    #12;
    checks++;
    if (slot(reg_q, 0) !== 32'hA5) $display("FAIL reset_r0: got %h expected %h",
                                            slot(reg_q, 0), 32'hA5);
    else passes++;
    checks++;
    if ({trig_out, irq, reg_rvalid, reg_err} !== '0)
      $display("FAIL reset_outputs: got trig %h irq %b rvalid %b err %b expected all 0",
               trig_out, irq, reg_rvalid, reg_err);
    else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    rd(0, 32'hA5);
    rd(1, 32'h1234_5678);
    rd(2, 32'h0);
    rd(3, 32'h0);
    idle(3);
    checks++;
    if (exp_q.size() != 0) $display("FAIL reset_reads_drained: got %0d expected 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_rw_ro;
    wr(0, 32'hDEAD_BEEF);
    rd(0, 32'hDEAD_BEEF);
    checks++;
    if (slot(reg_q, 0) !== 32'hDEAD_BEEF)
      $display("FAIL rw_reg_q: got %h expected %h", slot(reg_q, 0), 32'hDEAD_BEEF);
    else passes++;
    wr(1, 32'hFFFF_FFFF);
    rd(1, 32'h1234_5678);
    checks++;
    if (slot(reg_q, 1) !== 32'h0) $display("FAIL ro_reg_q: got %h expected 0", slot(reg_q, 1));
    else passes++;
    idle(2);
  endtask

  task automatic test_w1c;
    hw_in[67] = 1'b1;
    @(negedge clk);
    checks++;
    if (slot(reg_q, 2) !== 32'h8 || irq !== 1'b0)
      $display("FAIL w1c_set: got r2 %h irq %b expected 8 0", slot(reg_q, 2), irq);
    else passes++;
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) $display("FAIL w1c_irq_rise: got %b expected 1", irq);
    else passes++;
    wr(2, 32'h8);
    idle(1);
    checks++;
    if (slot(reg_q, 2) !== 32'h0 || irq !== 1'b1)
      $display("FAIL w1c_clear: got r2 %h irq %b expected 0 1", slot(reg_q, 2), irq);
    else passes++;
    idle(1);
    checks++;
    if (irq !== 1'b0) $display("FAIL w1c_irq_fall: got %b expected 0", irq);
    else passes++;
    idle(2);
    checks++;
    if (slot(reg_q, 2) !== 32'h0) $display("FAIL w1c_level_held: got %h expected 0",
                                          slot(reg_q, 2));
    else passes++;
    rd(2, 32'h0);
    idle(1);
    hw_in[67] = 1'b0;
    idle(1);
    hw_in[67] = 1'b1;
    idle(1);
    checks++;
    if (slot(reg_q, 2) !== 32'h8) $display("FAIL w1c_reset_edge: got %h expected 8",
                                          slot(reg_q, 2));
    else passes++;
    wr(2, 32'h8);
    idle(2);
    checks++;
    if (slot(reg_q, 2) !== 32'h0 || irq !== 1'b0)
      $display("FAIL w1c_cleanup: got r2 %h irq %b expected 0 0", slot(reg_q, 2), irq);
    else passes++;
  endtask

  task automatic test_set_wins;
    wr(2, 32'h1);
    hw_in[64] = 1'b1;
    idle(1);
    checks++;
    if (slot(reg_q, 2) !== 32'h1) $display("FAIL set_wins: got %h expected 1", slot(reg_q, 2));
    else passes++;
    idle(1);
    checks++;
    if (irq !== 1'b1) $display("FAIL set_wins_irq: got %b expected 1", irq);
    else passes++;
    wr(2, 32'h1);
    idle(1);
    checks++;
    if (slot(reg_q, 2) !== 32'h0) $display("FAIL set_wins_clear: got %h expected 0",
                                          slot(reg_q, 2));
    else passes++;
  endtask

  task automatic test_trig;
    wr(3, 32'h5);
    idle(1);
    checks++;
    if (trig_out !== {32'h5, 96'h0}) $display("FAIL trig_pulse: got %h expected %h",
                                              trig_out, {32'h5, 96'h0});
    else passes++;
    checks++;
    if (slot(reg_q, 3) !== 32'h0) $display("FAIL trig_reg_q: got %h expected 0", slot(reg_q, 3));
    else passes++;
    idle(1);
    checks++;
    if (trig_out !== '0) $display("FAIL trig_one_cycle: got %h expected 0", trig_out);
    else passes++;
    rd(0, 32'hDEAD_BEEF);
    rd(3, 32'h0);
    idle(2);
  endtask

  task automatic test_out_of_range;
    rd(0, 32'hDEAD_BEEF);
    rd(7, 32'h0);
    idle(1);
    checks++;
    if (reg_err !== 1'b1) $display("FAIL oob_read_err: got %b expected 1", reg_err);
    else passes++;
    idle(1);
    checks++;
    if (reg_err !== 1'b0) $display("FAIL oob_err_one_cycle: got %b expected 0", reg_err);
    else passes++;
    wr(5, 32'hFFFF_FFFF);
    idle(1);
    checks++;
    if (reg_err !== 1'b1) $display("FAIL oob_write_err: got %b expected 1", reg_err);
    else passes++;
    checks++;
    if (reg_q !== {96'h0, 32'hDEAD_BEEF} || trig_out !== '0)
      $display("FAIL oob_write_state: got reg_q %h trig %h expected %h 0",
               reg_q, trig_out, {96'h0, 32'hDEAD_BEEF});
    else passes++;
    idle(1);
  endtask

  task automatic test_back_to_back;
    rd(1, 32'h1234_5678);
    wr(0, 32'hCAFE_0001);
    checks++;
    if (reg_err !== 1'b0) $display("FAIL b2b_no_err: got %b expected 0", reg_err);
    else passes++;
    rd(0, 32'hCAFE_0001);
    wr(3, 32'h9);
    rd(2, 32'h0);
    checks++;
    if (slot(trig_out, 3) !== 32'h9) $display("FAIL b2b_trig: got %h expected 9",
                                              slot(trig_out, 3));
    else passes++;
    idle(2);
    checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_drained: got %0d expected 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_reset_mid;
    rd(0, 32'hCAFE_0001);
    @(posedge clk);
    #2;
    checks++;
    if (reg_rvalid !== 1'b1) $display("FAIL mid_rvalid_before: got %b expected 1", reg_rvalid);
    else passes++;
    reset_n = 1'b0;
    #1;
    reg_en = 1'b0;
    exp_q.delete();
    checks++;
    if (reg_rvalid !== 1'b0 || reg_rdata !== 32'h0)
      $display("FAIL mid_reset_drop: got rvalid %b rdata %h expected 0 0", reg_rvalid, reg_rdata);
    else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);
    checks++;
    if (reg_rvalid !== 1'b0 || trig_out !== '0 || slot(reg_q, 0) !== 32'hA5)
      $display("FAIL mid_after_reset: got rvalid %b trig %h r0 %h expected 0 0 a5",
               reg_rvalid, trig_out, slot(reg_q, 0));
    else passes++;
  endtask

  initial begin
    test_reset();
    test_rw_ro();
    test_w1c();
    test_set_wins();
    test_trig();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
